// File: rtl/present80_ctr_ctrl.sv
// Counter-mode keystream controller around an iterative PRESENT-80 round core.
// Emits E(key, ctr) for ctr = icb .. icb+nblk-1 over a valid/ready stream.

module present80 (
   input  logic        clk,
   input  logic        load,
   input  logic [63:0] indata,
   input  logic [79:0] key,
   output logic [63:0] outdata
);

   logic [63:0] state_q;
   logic [79:0] key_q;
   logic [4:0]  rc_q;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0:    y = 4'hC;
         4'h1:    y = 4'h5;
         4'h2:    y = 4'h6;
         4'h3:    y = 4'hB;
         4'h4:    y = 4'h9;
         4'h5:    y = 4'h0;
         4'h6:    y = 4'hA;
         4'h7:    y = 4'hD;
         4'h8:    y = 4'h3;
         4'h9:    y = 4'hE;
         4'hA:    y = 4'hF;
         4'hB:    y = 4'h8;
         4'hC:    y = 4'h4;
         4'hD:    y = 4'h7;
         4'hE:    y = 4'h1;
         4'hF:    y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] x);
      logic [63:0] y;
      y = 64'd0;
      for (int n = 0; n < 16; n++) begin
         y[n*4 +: 4] = sbox(x[n*4 +: 4]);
      end
      return y;
   endfunction

   // Bit i moves to 16*i mod 63; bit 63 stays in place.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      logic [5:0]  idx;
      y = 64'd0;
      for (int i = 0; i < 63; i++) begin
         idx    = 6'((i * 16) % 63);
         y[idx] = x[i];
      end
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] r;
      r          = {k[18:0], k[79:19]};
      r[79:76]   = sbox(r[79:76]);
      r[19:15]   = r[19:15] ^ rc;
      return r;
   endfunction

   // Round datapath: no reset and no enable, contents are meaningful only after load.
   always_ff @(posedge clk) begin
      if (load) begin
         state_q <= indata;
         key_q   <= key;
         rc_q    <= 5'd1;
      end else begin
         state_q <= p_layer(sbox_layer(state_q ^ key_q[79:16]));
         key_q   <= key_update(key_q, rc_q);
         rc_q    <= rc_q + 5'd1;
      end
   end

   assign outdata = state_q ^ key_q[79:16];

endmodule

module present80_ctr_ctrl #(
   parameter int NBLK_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [79:0]       cfg_key,
   input  logic [63:0]       cfg_icb,
   input  logic [NBLK_W-1:0] cfg_nblk,
   output logic              ks_valid,
   input  logic              ks_ready,
   output logic [63:0]       ks_data,
   output logic              ks_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      CAP  = 3'd3,
      WAIT = 3'd4
   } state_e;

   localparam logic [NBLK_W-1:0] NBLK_ONE = NBLK_W'(1'b1);

   state_e            state_q;
   logic [79:0]       key_q;
   logic [63:0]       ctr_q;
   logic [NBLK_W-1:0] remain_q;
   logic [4:0]        rnd_cnt_q;
   logic [63:0]       res_q;
   logic              res_full_q;
   logic              res_last_q;
   logic [63:0]       ks_data_q;
   logic              ks_valid_q;
   logic              ks_last_q;
   logic              done_q;

   logic              core_load_s;
   logic [63:0]       core_out_s;
   logic              res_move_s;
   logic              accept_s;
   logic              last_blk_s;

   present80 u_core (
      .clk     (clk),
      .load    (core_load_s),
      .indata  (ctr_q),
      .key     (key_q),
      .outdata (core_out_s)
   );

   assign core_load_s = (state_q == LOAD);
   assign res_move_s  = res_full_q && (!ks_valid_q || ks_ready);
   assign cfg_ready   = (state_q == IDLE) && !res_full_q && !ks_valid_q;
   assign accept_s    = cfg_valid && cfg_ready;
   assign last_blk_s  = (remain_q == NBLK_ONE);

   // Sequencer, two-entry output buffer (res -> ks) and completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         key_q      <= 80'd0;
         ctr_q      <= 64'd0;
         remain_q   <= {NBLK_W{1'b0}};
         rnd_cnt_q  <= 5'd0;
         res_q      <= 64'd0;
         res_full_q <= 1'b0;
         res_last_q <= 1'b0;
         ks_data_q  <= 64'd0;
         ks_valid_q <= 1'b0;
         ks_last_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= (ks_valid_q && ks_ready && ks_last_q) ||
                   (accept_s && (cfg_nblk == {NBLK_W{1'b0}}));

         if (res_move_s) begin
            ks_data_q  <= res_q;
            ks_last_q  <= res_last_q;
            ks_valid_q <= 1'b1;
            res_full_q <= 1'b0;
         end else if (ks_ready) begin
            ks_valid_q <= 1'b0;
         end else begin
            ks_valid_q <= ks_valid_q;
         end

         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  key_q    <= cfg_key;
                  ctr_q    <= cfg_icb;
                  remain_q <= cfg_nblk;
                  if (cfg_nblk == {NBLK_W{1'b0}}) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= LOAD;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            LOAD: begin
               rnd_cnt_q <= 5'd0;
               state_q   <= RUN;
            end
            RUN: begin
               rnd_cnt_q <= rnd_cnt_q + 5'd1;
               if (rnd_cnt_q == 5'd30) begin
                  state_q <= CAP;
               end else begin
                  state_q <= RUN;
               end
            end
            CAP: begin
               // res is guaranteed empty here: WAIT only leaves once it drains.
               res_q      <= core_out_s;
               res_full_q <= 1'b1;
               res_last_q <= last_blk_s;
               ctr_q      <= ctr_q + 64'd1;
               remain_q   <= remain_q - NBLK_ONE;
               if (last_blk_s) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (!res_full_q || res_move_s) begin
                  state_q <= LOAD;
               end else begin
                  state_q <= WAIT;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ks_valid = ks_valid_q;
   assign ks_data  = ks_data_q;
   assign ks_last  = ks_last_q;
   assign done     = done_q;
   assign busy     = (state_q != IDLE) || res_full_q || ks_valid_q;

endmodule

// File: tb/tb_present80_ctr_ctrl.sv
// Scoreboard bench for present80_ctr_ctrl: expected words come from a
// behavioural PRESENT-80 model (or known-answer constants) and are popped by a monitor.

module tb_present80_ctr_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [79:0] cfg_key = 80'd0;
   logic [63:0] cfg_icb = 64'd0;
   logic [15:0] cfg_nblk = 16'd0;
   logic        ks_valid;
   logic        ks_ready = 1'b0;
   logic [63:0] ks_data;
   logic        ks_last;
   logic        busy;
   logic        done;

   present80_ctr_ctrl #(.NBLK_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_key   (cfg_key),
      .cfg_icb   (cfg_icb),
      .cfg_nblk  (cfg_nblk),
      .ks_valid  (ks_valid),
      .ks_ready  (ks_ready),
      .ks_data   (ks_data),
      .ks_last   (ks_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [64:0] exp_q[$];
   int          hs_q[$];
   bit          pend_done = 1'b0;
   bit          zero_flag = 1'b0;
   int          rdy_mode = 0;
   int          accept_cyc = 0;

   logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   // Reference cipher: output bit j of the permutation gathers input bit 4*j mod 63.
   function automatic logic [63:0] ref_enc(input logic [79:0] k_in, input logic [63:0] p);
      logic [79:0] k;
      logic [63:0] s;
      logic [63:0] t;
      k = k_in;
      s = p;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
         for (int j = 0; j < 63; j++) s[j] = t[(4*j) % 63];
         s[63] = t[63];
         k = (k << 61) | (k >> 19);
         k[79:76] = SB[k[79:76]];
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_job(input logic [79:0] k, input logic [63:0] icb, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), ref_enc(k, icb + 64'(i))});
   endtask

   task automatic start_job(input logic [79:0] k, input logic [63:0] icb, input logic [15:0] n);
      int t;
      t = 0;
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_key   = k;
      cfg_icb   = icb;
      cfg_nblk  = n;
      @(negedge clk);
      while (!cfg_ready && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!cfg_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: cfg_ready=%0b required 1", cfg_ready);
         cfg_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         cfg_valid  = 1'b0;
         accept_cyc = cyc;
         if (n == 16'd0) zero_flag = 1'b1;
      end
   endtask

   task automatic wait_valid(input int maxc);
      int t;
      t = 0;
      @(negedge clk);
      while (!ks_valid && t < maxc) begin
         @(negedge clk);
         t++;
      end
      if (!ks_valid) begin
         n_checks++;
         n_errors++;
         $display("FAIL valid_timeout: ks_valid=%0b required 1", ks_valid);
      end
   endtask

   task automatic wait_idle(input int maxc);
      int t;
      t = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && t < maxc) begin
         @(negedge clk);
         t++;
      end
      if (busy || exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain_timeout: busy=%0b pending=%0d required 0/0", busy, exp_q.size());
      end
   endtask

   // Ready driver: 0 = always ready, 1 = held off, otherwise random.
   initial begin
      forever begin
         @(posedge clk); #2;
         case (rdy_mode)
            0:       ks_ready = 1'b1;
            1:       ks_ready = 1'b0;
            default: ks_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks the done pulse.
   always @(negedge clk) begin
      logic [64:0] e;
      if (!rst_n) begin
         pend_done = 1'b0;
         zero_flag = 1'b0;
      end else begin
         chk("done", 64'(done), 64'(pend_done || zero_flag));
         pend_done = 1'b0;
         zero_flag = 1'b0;
         if (ks_valid && ks_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got %h with nothing expected", ks_data);
            end else begin
               e = exp_q.pop_front();
               chk("ks_data", ks_data, e[63:0]);
               chk("ks_last", 64'(ks_last), 64'(e[64]));
               pend_done = e[64];
               hs_q.push_back(cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ks_valid", 64'(ks_valid), 64'd0);
      chk("rst_ks_last", 64'(ks_last), 64'd0);
      chk("rst_ks_data", ks_data, 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ctr", dut.ctr_q, 64'd0);
      chk("rst_remain", 64'(dut.remain_q), 64'd0);
      chk("rst_rnd_cnt", 64'(dut.rnd_cnt_q), 64'd0);
      chk("rst_res_full", 64'(dut.res_full_q), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Known answers, latency and busy fall
      rdy_mode = 0;
      exp_q.push_back({1'b1, 64'h5579C1387B228445});
      start_job(80'd0, 64'd0, 16'd1);
      wait_valid(100);
      chk("first_latency", 64'(cyc - accept_cyc), 64'd34);
      wait_idle(200);
      chk("busy_after", 64'(busy), 64'd0);

      exp_q.push_back({1'b1, 64'hE72C46C0F5945049});
      start_job({80{1'b1}}, 64'd0, 16'd1);
      wait_idle(200);
      exp_q.push_back({1'b1, 64'h3333DCD3213210D2});
      start_job({80{1'b1}}, {64{1'b1}}, 16'd1);
      wait_idle(200);

      // Counter wrap and word spacing
      hs_q.delete();
      exp_q.push_back({1'b0, 64'hA112FFC72F68417B});
      exp_q.push_back({1'b1, 64'h5579C1387B228445});
      start_job(80'd0, {64{1'b1}}, 16'd2);
      wait_idle(300);
      chk("wrap_words", 64'(hs_q.size()), 64'd2);
      if (hs_q.size() >= 2) chk("word_spacing", 64'(hs_q[1] - hs_q[0]), 64'd34);

      // Backpressure: park with both buffers full
      rdy_mode = 1;
      push_job(80'd0, 64'd0, 4);
      start_job(80'd0, 64'd0, 16'd4);
      wait_valid(100);
      repeat (150) begin
         @(negedge clk);
         chk("bp_hold_data", ks_data, 64'h5579C1387B228445);
         chk("bp_hold_valid", 64'(ks_valid), 64'd1);
      end
      chk("bp_res_full", 64'(dut.res_full_q), 64'd1);
      chk("bp_cfg_ready", 64'(cfg_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      rdy_mode = 0;
      wait_idle(400);

      // Zero-length job
      start_job({$urandom(), $urandom(), 16'($urandom())}, {$urandom(), $urandom()}, 16'd0);
      repeat (5) begin
         @(negedge clk);
         chk("zero_no_valid", 64'(ks_valid), 64'd0);
         chk("zero_busy", 64'(busy), 64'd0);
      end

      // Requests during a job are ignored
      exp_q.push_back({1'b1, 64'h5579C1387B228445});
      start_job(80'd0, 64'd0, 16'd1);
      @(posedge clk); #1;
      cfg_valid = 1'b1;
      cfg_key   = {$urandom(), $urandom(), 16'($urandom())};
      cfg_nblk  = 16'd5;
      repeat (10) begin
         @(negedge clk);
         chk("busy_cfg_ready", 64'(cfg_ready), 64'd0);
      end
      cfg_valid = 1'b0;
      wait_idle(200);

      // Randomised jobs under random backpressure
      rdy_mode = 2;
      for (int j = 0; j < 8; j++) begin
         logic [79:0] k;
         logic [63:0] icb;
         int          n;
         k   = {$urandom(), $urandom(), 16'($urandom())};
         icb = (j % 3 == 0) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom(), $urandom()};
         n   = $urandom_range(1, 3);
         push_job(k, icb, n);
         start_job(k, icb, 16'(n));
         wait_idle(800);
      end

      // Reset in RUN of block 2 of a 3-block job
      rdy_mode = 1;
      push_job(80'd0, 64'd0, 3);
      start_job(80'd0, 64'd0, 16'd3);
      repeat (45) @(posedge clk);
      #3 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_ks_valid", 64'(ks_valid), 64'd0);
      chk("mid_rst_ks_data", ks_data, 64'd0);
      chk("mid_rst_ks_last", 64'(ks_last), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
      rdy_mode = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("post_rst_idle", 64'(busy), 64'd0);
      exp_q.push_back({1'b1, 64'h5579C1387B228445});
      start_job(80'd0, 64'd0, 16'd1);
      wait_idle(200);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
